lcd_cmd_sequencer: RTL

- Parametrised successor of the LCD controller's internal command FSM.
- Accepts 10-bit LCD transfers {rw, rs, data[7:0]} over a valid/ready handshake.
- Drives the character LCD over a 4-bit (two nibbles) or 8-bit (single strobe) bus, with all timing derived from cycle-count parameters.
- Applies a long execution wait for Clear Display and Return Home; short wait otherwise. Sits between the LCD controller's command buffer and the LCD pins.

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_wait_counter.sv | 25 ++
 rtl/lcd_cmd_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - state encodings, command fields and default timing for the LCD command sequencer
package lcd_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SETUP      = 4'd1,
    S_PULSE_HI   = 4'd2,
    S_GAP        = 4'd3,
    S_PULSE_LO   = 4'd4,
    S_EXEC       = 4'd5,
    S_INIT_WAIT  = 4'd6,
    S_INIT_SETUP = 4'd7,
    S_INIT_PULSE = 4'd8,
    S_INIT_EXEC  = 4'd9
  } lcd_state_e;

  localparam int CMD_W      = 10;
  localparam int CMD_RW_BIT = 9;
  localparam int CMD_RS_BIT = 8;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  localparam logic [7:0] LCD_INIT_WAKE = 8'h30;
  localparam logic [7:0] LCD_INIT_4BIT = 8'h20;

  localparam int DEF_SETUP_CYC      = 5;
  localparam int DEF_PULSE_CYC      = 14;
  localparam int DEF_GAP_CYC        = 50;
  localparam int DEF_HOLD_CYC       = 10;
  localparam int DEF_CMD_WAIT_CYC   = 2000;
  localparam int DEF_LONG_WAIT_CYC  = 82000;
  localparam int DEF_INIT_WAIT_CYC  = 750000;
  // 4.1 ms at 50 MHz after the first wake-up strobe
  localparam int DEF_INIT_FIRST_CYC = 205000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear Display and Return Home need the long execution wait
  function automatic logic is_long_cmd(input logic [CMD_W-1:0] cmd);
    return !cmd[CMD_RW_BIT] && !cmd[CMD_RS_BIT] &&
           (cmd[7:0] == LCD_CMD_CLEAR || cmd[7:0] == LCD_CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_wait_counter.sv
// rtl/lcd_wait_counter.sv - clearable saturating cycle counter with terminal-count compare
module lcd_wait_counter
  import lcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != {WIDTH{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - LCD transfer sequencer for 4/8-bit character LCD buses
// Optional power-on init sequence: define LCD_POWER_INIT_EN.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH     = 4,
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int PULSE_CYC     = DEF_PULSE_CYC,
  parameter int GAP_CYC       = DEF_GAP_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int CMD_WAIT_CYC  = DEF_CMD_WAIT_CYC,
  parameter int LONG_WAIT_CYC = DEF_LONG_WAIT_CYC,
  parameter int INIT_WAIT_CYC = DEF_INIT_WAIT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [CMD_W-1:0]     cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 busy,
  output logic [BUS_WIDTH-1:0] lcd_data,
  output logic                 lcd_e,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 sf_ce0
);

  localparam int MAX_CYC = max_int(
    max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(GAP_CYC, HOLD_CYC)),
    max_int(max_int(CMD_WAIT_CYC, LONG_WAIT_CYC), max_int(INIT_WAIT_CYC, DEF_INIT_FIRST_CYC)));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  lcd_state_e           state, state_next;
  logic [CMD_W-1:0]     cmd_q;
  logic [CNT_W-1:0]     count, terminal;
  logic                 done, accept, exec_last, clear;
  logic [BUS_WIDTH-1:0] first_word, low_word;

`ifdef LCD_POWER_INIT_EN
  localparam logic [1:0] INIT_LAST = (BUS_WIDTH == 4) ? 2'd3 : 2'd2;
  logic [1:0]           init_idx, init_idx_next;
  logic [BUS_WIDTH-1:0] init_word;

  assign init_word = (init_idx_next == 2'd3) ? LCD_INIT_4BIT[7 -: BUS_WIDTH]
                                             : LCD_INIT_WAKE[7 -: BUS_WIDTH];
`endif

  // Upper nibble first in 4-bit mode, whole byte in 8-bit mode
  assign first_word = cmd_data[7 -: BUS_WIDTH];
  assign low_word   = cmd_q[BUS_WIDTH-1:0];

  assign exec_last = (state == S_EXEC) && done;
  assign cmd_ready = (state == S_IDLE || exec_last) && enable && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign sf_ce0    = 1'b0;
  assign clear     = (state_next != state);

  lcd_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .terminal(terminal),
    .count   (count),
    .done    (done)
  );

  always_comb begin
    state_next = state;
    terminal   = '0;
`ifdef LCD_POWER_INIT_EN
    init_idx_next = init_idx;
`endif
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_SETUP;
      end
      S_SETUP: begin
        terminal = CNT_W'(SETUP_CYC - 1);
        if (done) state_next = S_PULSE_HI;
      end
      S_PULSE_HI: begin
        terminal = CNT_W'(PULSE_CYC - 1);
        if (done) state_next = (BUS_WIDTH == 4) ? S_GAP : S_EXEC;
      end
      S_GAP: begin
        terminal = CNT_W'(GAP_CYC - 1);
        if (done) state_next = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        terminal = CNT_W'(PULSE_CYC - 1);
        if (done) state_next = S_EXEC;
      end
      S_EXEC: begin
        terminal = is_long_cmd(cmd_q) ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        if (done) state_next = accept ? S_SETUP : S_IDLE;
      end
`ifdef LCD_POWER_INIT_EN
      S_INIT_WAIT: begin
        terminal = CNT_W'(INIT_WAIT_CYC - 1);
        if (done) state_next = S_INIT_SETUP;
      end
      S_INIT_SETUP: begin
        terminal = CNT_W'(SETUP_CYC - 1);
        if (done) state_next = S_INIT_PULSE;
      end
      S_INIT_PULSE: begin
        terminal = CNT_W'(PULSE_CYC - 1);
        if (done) state_next = S_INIT_EXEC;
      end
      S_INIT_EXEC: begin
        terminal = (init_idx == 2'd0) ? CNT_W'(DEF_INIT_FIRST_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        if (done) begin
          if (init_idx == INIT_LAST) begin
            state_next = S_IDLE;
          end else begin
            init_idx_next = init_idx + 2'd1;
            state_next    = S_INIT_SETUP;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LCD_POWER_INIT_EN
      state    <= S_INIT_WAIT;
      init_idx <= 2'd0;
`else
      state    <= S_IDLE;
`endif
    end else begin
      state <= state_next;
`ifdef LCD_POWER_INIT_EN
      init_idx <= init_idx_next;
`endif
    end
  end

  // Pins are registered from the next state so lcd_e lines up with PULSE_* states
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      lcd_data <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
    end else begin
      lcd_e <= (state_next == S_PULSE_HI) || (state_next == S_PULSE_LO) ||
               (state_next == S_INIT_PULSE);
      if (accept) begin
        cmd_q    <= cmd_data;
        lcd_data <= first_word;
        lcd_rs   <= cmd_data[CMD_RS_BIT];
        lcd_rw   <= cmd_data[CMD_RW_BIT];
      end else if (state_next == S_IDLE) begin
        lcd_data <= '0;
        lcd_rs   <= 1'b0;
        lcd_rw   <= 1'b0;
      end else if (state == S_GAP && (count == HOLD_LAST || done)) begin
        lcd_data <= low_word;
      end else if ((state == S_EXEC || state == S_INIT_EXEC) && count == HOLD_LAST) begin
        lcd_data <= '0;
        lcd_rs   <= 1'b0;
        lcd_rw   <= 1'b0;
`ifdef LCD_POWER_INIT_EN
      end else if (state_next == S_INIT_SETUP && state != S_INIT_SETUP) begin
        lcd_data <= init_word;
        lcd_rs   <= 1'b0;
        lcd_rw   <= 1'b0;
`endif
      end
    end
  end

endmodule
